// File: rtl/rv32i_dmem_arbiter.sv
// Two-requester (CPU / aux) arbiter for a single-port RV32I data memory: IDLE -> ISSUE -> RESP, one transaction in flight.
// Define DMEM_ARB_FAIRNESS_EN to enable the aux starvation counter; otherwise the CPU has strict priority.
module rv32i_dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_wr,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [3:0]  i_cpu_mask,
    output logic        o_cpu_ack,
    output logic [31:0] o_cpu_rdata,
    input  logic        i_aux_req,
    input  logic        i_aux_wr,
    input  logic [31:0] i_aux_addr,
    input  logic [31:0] i_aux_wdata,
    input  logic [3:0]  i_aux_mask,
    output logic        o_aux_ack,
    output logic [31:0] o_aux_rdata,
    output logic        o_mem_en,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;      // 1 = aux owns the transaction
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] aux_rdata_q, aux_rdata_d;
    logic        aux_wins;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] cnt_q, cnt_d;

    assign aux_wins = i_aux_req && (!i_cpu_req || cnt_q == LIMIT_C);
`else
    assign aux_wins = i_aux_req && !i_cpu_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
`ifdef DMEM_ARB_FAIRNESS_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_cpu_req || i_aux_req) begin
                    state_d = S_ISSUE;
                    owner_d = aux_wins;
                    wr_d    = aux_wins ? i_aux_wr    : i_cpu_wr;
                    addr_d  = aux_wins ? i_aux_addr  : i_cpu_addr;
                    wdata_d = aux_wins ? i_aux_wdata : i_cpu_wdata;
                    mask_d  = aux_wins ? i_aux_mask  : i_cpu_mask;
`ifdef DMEM_ARB_FAIRNESS_EN
                    if (aux_wins || !i_aux_req)
                        cnt_d = '0;
                    else
                        cnt_d = (cnt_q >= LIMIT_C) ? LIMIT_C : cnt_q + 4'd1;
`endif
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP: begin
                state_d = S_IDLE;
                if (!wr_q) begin
                    if (owner_q) aux_rdata_d = i_mem_rdata;
                    else         cpu_rdata_d = i_mem_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
`ifdef DMEM_ARB_FAIRNESS_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
`ifdef DMEM_ARB_FAIRNESS_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign o_mem_en    = (state_q == S_ISSUE);
    assign o_mem_wr    = wr_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_mask  = mask_q;

    assign o_cpu_ack   = (state_q == S_RESP) && !owner_q;
    assign o_aux_ack   = (state_q == S_RESP) &&  owner_q;

    // Read data arrives during RESP; forward it alongside the ack, then hold the latched copy.
    assign o_cpu_rdata = (o_cpu_ack && !wr_q) ? i_mem_rdata : cpu_rdata_q;
    assign o_aux_rdata = (o_aux_ack && !wr_q) ? i_mem_rdata : aux_rdata_q;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Directed bench for rv32i_dmem_arbiter; expected grant order follows DMEM_ARB_FAIRNESS_EN.
module tb_rv32i_dmem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cpu_req = 1'b0, i_cpu_wr = 1'b0;
    logic [31:0] i_cpu_addr = '0, i_cpu_wdata = '0;
    logic [3:0]  i_cpu_mask = '0;
    logic        o_cpu_ack;
    logic [31:0] o_cpu_rdata;
    logic        i_aux_req = 1'b0, i_aux_wr = 1'b0;
    logic [31:0] i_aux_addr = '0, i_aux_wdata = '0;
    logic [3:0]  i_aux_mask = '0;
    logic        o_aux_ack;
    logic [31:0] o_aux_rdata;
    logic        o_mem_en, o_mem_wr;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic [31:0] i_mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    rv32i_dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpu_req(i_cpu_req), .i_cpu_wr(i_cpu_wr), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .i_cpu_mask(i_cpu_mask),
        .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
        .i_aux_req(i_aux_req), .i_aux_wr(i_aux_wr), .i_aux_addr(i_aux_addr),
        .i_aux_wdata(i_aux_wdata), .i_aux_mask(i_aux_mask),
        .o_aux_ack(o_aux_ack), .o_aux_rdata(o_aux_rdata),
        .o_mem_en(o_mem_en), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    initial begin
        logic [1:0] exp_grant;

        // Reset state
        cyc();
        chk("rst_mem_en", {31'd0, o_mem_en}, 32'd0);
        chk("rst_mem_wr", {31'd0, o_mem_wr}, 32'd0);
        chk("rst_acks", {30'd0, o_cpu_ack, o_aux_ack}, 32'd0);
        chk("rst_cpu_rdata", o_cpu_rdata, 32'd0);
        chk("rst_aux_rdata", o_aux_rdata, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        i_rst = 1'b0;
        cyc();

        // CPU read of 0x10
        i_cpu_req = 1'b1; i_cpu_wr = 1'b0; i_cpu_addr = 32'h10; i_cpu_mask = 4'hF;
        i_mem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("rd_issue_en", {31'd0, o_mem_en}, 32'd1);
        chk("rd_issue_addr", o_mem_addr, 32'h10);
        chk("rd_issue_wr", {31'd0, o_mem_wr}, 32'd0);
        chk("rd_issue_acks", {30'd0, o_cpu_ack, o_aux_ack}, 32'd0);
        cyc();
        chk("rd_resp_acks", {30'd0, o_cpu_ack, o_aux_ack}, 32'd2);
        chk("rd_resp_rdata", o_cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_resp_en", {31'd0, o_mem_en}, 32'd0);
        i_cpu_req = 1'b0;
        cyc();
        i_mem_rdata = 32'h0;
        #1;
        chk("rd_idle_acks", {30'd0, o_cpu_ack, o_aux_ack}, 32'd0);
        chk("rd_idle_hold", o_cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_idle_addr_hold", o_mem_addr, 32'h10);

        // Aux write; field change during ISSUE must be ignored
        i_aux_req = 1'b1; i_aux_wr = 1'b1; i_aux_addr = 32'h20;
        i_aux_wdata = 32'h1234_5678; i_aux_mask = 4'b0011;
        cyc();
        chk("wr_issue_en", {31'd0, o_mem_en}, 32'd1);
        chk("wr_issue_wr", {31'd0, o_mem_wr}, 32'd1);
        chk("wr_issue_addr", o_mem_addr, 32'h20);
        chk("wr_issue_wdata", o_mem_wdata, 32'h1234_5678);
        chk("wr_issue_mask", {28'd0, o_mem_mask}, 32'h3);
        i_aux_addr = 32'h99; i_aux_wdata = 32'hFFFF_FFFF; i_mem_rdata = 32'h5555_AAAA;
        cyc();
        chk("wr_resp_acks", {30'd0, o_cpu_ack, o_aux_ack}, 32'd1);
        chk("wr_resp_aux_rdata", o_aux_rdata, 32'd0);
        chk("wr_resp_cpu_rdata", o_cpu_rdata, 32'hDEAD_BEEF);
        chk("wr_resp_addr_hold", o_mem_addr, 32'h20);
        i_aux_req = 1'b0; i_aux_wr = 1'b0;
        cyc();
        chk("wr_idle_aux_rdata", o_aux_rdata, 32'd0);

        // Both requesting continuously: fairness rotation or strict CPU priority
        i_cpu_req = 1'b1; i_cpu_wr = 1'b0; i_cpu_addr = 32'h40;
        i_aux_req = 1'b1; i_aux_wr = 1'b0; i_aux_addr = 32'h80;
        i_mem_rdata = 32'h0000_0C0C;
        for (int k = 0; k < 10; k++) begin
`ifdef DMEM_ARB_FAIRNESS_EN
            exp_grant = (k % 5 == 4) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b10;
`endif
            cyc();
            chk($sformatf("both_issue_en_%0d", k), {31'd0, o_mem_en}, 32'd1);
            chk($sformatf("both_issue_addr_%0d", k), o_mem_addr,
                exp_grant[0] ? 32'h80 : 32'h40);
            cyc();
            chk($sformatf("both_grant_%0d", k), {30'd0, o_cpu_ack, o_aux_ack}, {30'd0, exp_grant});
            cyc();
        end
        i_cpu_req = 1'b0; i_aux_req = 1'b0;
        cyc();

        // Reset asserted during ISSUE of a CPU read
        i_cpu_req = 1'b1; i_cpu_addr = 32'h30; i_mem_rdata = 32'h7777_7777;
        cyc();
        chk("rst_mid_en_before", {31'd0, o_mem_en}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_mid_en", {31'd0, o_mem_en}, 32'd0);
        chk("rst_mid_acks", {30'd0, o_cpu_ack, o_aux_ack}, 32'd0);
        chk("rst_mid_addr", o_mem_addr, 32'd0);
        chk("rst_mid_cpu_rdata", o_cpu_rdata, 32'd0);
        cyc();
        chk("rst_mid_noack", {30'd0, o_cpu_ack, o_aux_ack}, 32'd0);
        i_rst = 1'b0; i_cpu_addr = 32'h44; i_mem_rdata = 32'h0BAD_F00D;
        cyc();
        chk("post_rst_issue_en", {31'd0, o_mem_en}, 32'd1);
        chk("post_rst_issue_addr", o_mem_addr, 32'h44);
        cyc();
        chk("post_rst_ack", {30'd0, o_cpu_ack, o_aux_ack}, 32'd2);
        chk("post_rst_rdata", o_cpu_rdata, 32'h0BAD_F00D);
        i_cpu_req = 1'b0;
        cyc();

        // Back-to-back CPU reads, new address presented the cycle after each ack
        i_cpu_req = 1'b1; i_cpu_addr = 32'h100; i_mem_rdata = 32'h1111_0000;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("b2b_issue_en_%0d", k), {31'd0, o_mem_en}, 32'd1);
            chk($sformatf("b2b_issue_addr_%0d", k), o_mem_addr, 32'h100 + 32'(4 * k));
            cyc();
            chk($sformatf("b2b_ack_%0d", k), {30'd0, o_cpu_ack, o_aux_ack}, 32'd2);
            chk($sformatf("b2b_rdata_%0d", k), o_cpu_rdata, 32'h1111_0000 + 32'(k));
            cyc();
            chk($sformatf("b2b_idle_%0d", k), {30'd0, o_cpu_ack, o_aux_ack, o_mem_en}, 32'd0);
            if (k < 3) begin
                i_cpu_addr  = 32'h100 + 32'(4 * (k + 1));
                i_mem_rdata = 32'h1111_0000 + 32'(k + 1);
            end else begin
                i_cpu_req = 1'b0;
            end
        end
        cyc();
        chk("final_aux_rdata", o_aux_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_dmem_arbiter.md
RV32I_DMEM_ARBITER -- requirements
Module: rv32i_dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive CPU grants allowed while aux request waits (range 1..15).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_cpu_req/i_cpu_wr  input  1 each  CPU (memory-access stage) request, write-not-read.
REQ-005 SHALL have ports i_cpu_addr  input  32, i_cpu_wdata  input  32, i_cpu_mask  input  4  CPU address, mask-aligned store data, byte mask.
REQ-006 SHALL have ports o_cpu_ack  output  1, o_cpu_rdata  output  32  CPU completion pulse, read data.
REQ-007 SHALL have ports i_aux_req, i_aux_wr, i_aux_addr, i_aux_wdata, i_aux_mask, o_aux_ack, o_aux_rdata, identical widths and meanings for the auxiliary (debug/DMA) requester.
REQ-008 SHALL have ports o_mem_en  output  1, o_mem_wr  output  1, o_mem_addr  output  32, o_mem_wdata  output  32, o_mem_mask  output  4  single-port data memory command.
REQ-009 SHALL have port i_mem_rdata  input  32  memory read data, valid the cycle after o_mem_en.

Function
REQ-010 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; one transaction in flight maximum.
REQ-011 IDLE: if any request high, SHALL select winner, register its wr/addr/wdata/mask and owner, go ISSUE; else stay IDLE.
REQ-012 ISSUE: SHALL drive o_mem_en=1 for exactly one cycle with registered fields, o_mem_wr=registered wr; go RESP.
REQ-013 RESP: SHALL pulse owner's ack for one cycle; on read SHALL load owner's rdata from i_mem_rdata; on write owner's rdata SHALL hold; go IDLE.
REQ-014 Latency: request sampled in IDLE at edge N -> o_mem_en in cycle N+1 -> ack in cycle N+2; three cycles per transaction.
REQ-015 Requester SHALL hold req and fields until ack; req must be low (or a new request) in the cycle after ack; arbiter SHALL ignore field changes after capture.
REQ-016 o_mem_en SHALL be 0 in IDLE and RESP; o_mem_* other outputs SHALL hold last registered values.
REQ-017 Non-winning ack SHALL stay 0; both acks SHALL never be high together.
REQ-018 Simultaneous requests: CPU SHALL win unless the starvation counter equals STARVE_LIMIT, then aux SHALL win.
REQ-019 Starvation counter (4 bit) SHALL increment on each CPU grant with i_aux_req high, clear on aux grant or when aux_req low at a CPU grant; SHALL saturate at STARVE_LIMIT.
REQ-020 Lone requester SHALL be granted immediately regardless of counter.
REQ-021 Address, data, mask SHALL pass through unmodified; alignment is the requester's duty.

Reset
REQ-022 On i_rst high, immediately and asynchronously: FSM=IDLE, o_mem_en=0, o_mem_wr=0, acks=0, rdata outputs=0, counter=0, captured fields=0.
REQ-023 Reset mid-transaction SHALL abort it with no ack; first request after release SHALL be sampled at the first rising edge with i_rst low.

Configuration
REQ-024 Macro DMEM_ARB_FAIRNESS_EN defined: starvation counter and REQ-018/019 behaviour present.
REQ-025 Macro undefined: no counter logic; CPU SHALL always win simultaneous requests (strict priority); STARVE_LIMIT ignored.

Verification
REQ-026 CPU read addr 0x0000_0010, memory word 0xDEAD_BEEF -> o_mem_en in cycle N+1 with addr 0x10, o_cpu_ack and o_cpu_rdata=0xDEAD_BEEF in cycle N+2.
REQ-027 Aux write addr 0x20, wdata 0x1234_5678, mask 4'b0011 -> o_mem_wr=1, mask 0011 in ISSUE; o_aux_ack cycle N+2; o_aux_rdata unchanged.
REQ-028 Both requesting continuously, STARVE_LIMIT=4, macro defined -> grant order CPU,CPU,CPU,CPU,AUX repeating; macro undefined -> aux never granted.
REQ-029 i_rst asserted during ISSUE of CPU read -> o_mem_en drops immediately, no ack, all outputs zero; post-release CPU request completes in 3 cycles.
REQ-030 Back-to-back CPU reads, req held high with new address the cycle after ack -> every transaction exactly 3 cycles, acks never overlap, o_aux_ack stays 0.
